sccb_slave_model: RTL and testbench

- SCCB responder that mirrors the OV5642 register interface on the camera side of the bus.
- Decodes START/STOP and receives the 8-bit device ID, the 16-bit register address and the data byte. Drives ACK and read data back onto SIOD.
- Holds a small register file, so the SCCB initiator and init sequencer can be closed-loop tested on the bench or in FPGA loopback without a camera.
- Fully synthesizable; samples the bus in the i_clk domain.

---
 rtl/sccb_pkg.sv | 22 ++
 rtl/sccb_edge_det.sv | 52 +++++
 rtl/sccb_slave_model.sv | 202 ++++++++++++++++++++
 tb/tb_sccb_slave_model.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared state encoding and bus constants for the SCCB responder model.
package sccb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID,
    S_ID_ACK,
    S_ADDR_H,
    S_ADDR_H_ACK,
    S_ADDR_L,
    S_ADDR_L_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_NACK,
    S_WAIT_STOP
  } sccb_state_e;

  localparam logic [7:0] DEF_DEV_ADDR = 8'h78;
  localparam logic [7:0] READ_BIT     = 8'h01;

endpackage

// File: rtl/sccb_edge_det.sv
// Synchronises SIOC/SIOD into i_clk and flags SIOC edges plus START/STOP conditions.
module sccb_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sioc,
  input  logic i_siod,
  output logic o_siod,
  output logic o_sioc_rise,
  output logic o_sioc_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  logic [SYNC_STAGES-1:0] sioc_sync_q, sioc_sync_d;
  logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
  logic                   sioc_prev_q, sioc_prev_d;
  logic                   siod_prev_q, siod_prev_d;
  logic                   sioc_s;

  assign sioc_s = sioc_sync_q[SYNC_STAGES-1];
  assign o_siod = siod_sync_q[SYNC_STAGES-1];

  always_comb begin
    sioc_sync_d = {sioc_sync_q[SYNC_STAGES-2:0], i_sioc};
    siod_sync_d = {siod_sync_q[SYNC_STAGES-2:0], i_siod};
    sioc_prev_d = sioc_s;
    siod_prev_d = o_siod;
  end

  // Idle bus is high on both lines, so reset to '1 to avoid a false edge after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_prev_q <= 1'b1;
      siod_prev_q <= 1'b1;
    end else begin
      sioc_sync_q <= sioc_sync_d;
      siod_sync_q <= siod_sync_d;
      sioc_prev_q <= sioc_prev_d;
      siod_prev_q <= siod_prev_d;
    end
  end

  assign o_sioc_rise = sioc_s & ~sioc_prev_q;
  assign o_sioc_fall = ~sioc_s & sioc_prev_q;
  assign o_start_det = sioc_s & sioc_prev_q & siod_prev_q & ~o_siod;
  assign o_stop_det  = sioc_s & sioc_prev_q & ~siod_prev_q & o_siod;

endmodule

// File: rtl/sccb_slave_model.sv
// SCCB responder emulating an OV5642 register interface backed by a small register file.
module sccb_slave_model
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR    = DEF_DEV_ADDR,
  parameter int unsigned ADDR_BITS   = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sioc,
  input  logic        i_siod_in,
  output logic        o_siod_out,
  output logic        o_siod_oe,
  output logic        o_wr_valid,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_rd_valid,
  output logic        o_busy,
  output logic        o_id_err
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic siod, sioc_rise, sioc_fall, start_det, stop_det;

  sccb_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge_det (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sioc      (i_sioc),
    .i_siod      (i_siod_in),
    .o_siod      (siod),
    .o_sioc_rise (sioc_rise),
    .o_sioc_fall (sioc_fall),
    .o_start_det (start_det),
    .o_stop_det  (stop_det)
  );

  sccb_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [15:0] addr_q, addr_d;
  logic        oe_q, oe_d, out_q, out_d;
  logic        wr_valid_q, wr_valid_d, rd_valid_q, rd_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        id_err_q, id_err_d;
  logic [7:0]  mem_q [DEPTH];
  logic        mem_we;
  logic [7:0]  mem_wdata, rd_byte;

  assign rd_byte = mem_q[addr_q[ADDR_BITS-1:0]];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    addr_d     = addr_q;
    oe_d       = oe_q;
    out_d      = out_q;
    wr_valid_d = 1'b0;
    rd_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    id_err_d   = id_err_q;
    mem_we     = 1'b0;
    mem_wdata  = {sh_q[6:0], siod};

    if (stop_det) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      out_d   = 1'b1;
    end else if (start_det) begin
      state_d = S_ID;
      cnt_d   = '0;
      oe_d    = 1'b0;
      out_d   = 1'b1;
    end else begin
      case (state_q)
        S_ID, S_ADDR_H, S_ADDR_L, S_WR_DATA: begin
          if (sioc_rise && cnt_q < 4'd8) begin
            sh_d  = {sh_q[6:0], siod};
            cnt_d = cnt_q + 4'd1;
            if (state_q == S_WR_DATA && cnt_q == 4'd7) begin
              mem_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = mem_wdata;
            end
          end else if (sioc_fall && cnt_q == 4'd8) begin
            // Falling edge after the 8th bit: start the ACK slot for accepted bytes.
            oe_d  = 1'b1;
            out_d = 1'b0;
            if (state_q == S_ID) begin
              if ((sh_q | READ_BIT) == (DEV_ADDR | READ_BIT)) begin
                state_d = S_ID_ACK;
              end else begin
                state_d  = S_WAIT_STOP;
                oe_d     = 1'b0;
                out_d    = 1'b1;
                id_err_d = 1'b1;
              end
            end else if (state_q == S_ADDR_H) begin
              addr_d[15:8] = sh_q;
              state_d      = S_ADDR_H_ACK;
            end else if (state_q == S_ADDR_L) begin
              addr_d[7:0] = sh_q;
              state_d     = S_ADDR_L_ACK;
            end else begin
              state_d = S_WR_ACK;
            end
          end
        end
        S_ID_ACK: begin
          if (sioc_fall) begin
            cnt_d = '0;
            if ((sh_q & READ_BIT) != '0) begin
              state_d = S_RD_DATA;
              oe_d    = 1'b1;
              out_d   = rd_byte[7];
              sh_d    = {rd_byte[6:0], 1'b0};
            end else begin
              state_d = S_ADDR_H;
              oe_d    = 1'b0;
              out_d   = 1'b1;
            end
          end
        end
        S_ADDR_H_ACK, S_ADDR_L_ACK, S_WR_ACK: begin
          if (sioc_fall) begin
            cnt_d = '0;
            oe_d  = 1'b0;
            out_d = 1'b1;
            if (state_q == S_ADDR_H_ACK) state_d = S_ADDR_L;
            else if (state_q == S_ADDR_L_ACK) state_d = S_WR_DATA;
            else state_d = S_WAIT_STOP;
          end
        end
        S_RD_DATA: begin
          if (sioc_rise && cnt_q < 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (sioc_fall) begin
            if (cnt_q == 4'd8) begin
              state_d    = S_RD_NACK;
              oe_d       = 1'b0;
              out_d      = 1'b1;
              rd_valid_d = 1'b1;
            end else begin
              out_d = sh_q[7];
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
        end
        S_RD_NACK: begin
          if (sioc_rise) state_d = S_WAIT_STOP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      addr_q     <= '0;
      oe_q       <= 1'b0;
      out_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      id_err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      id_err_q   <= id_err_d;
      if (mem_we) mem_q[addr_q[ADDR_BITS-1:0]] <= mem_wdata;
    end
  end

  assign o_siod_out = out_q;
  assign o_siod_oe  = oe_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_id_err   = id_err_q;

endmodule

// File: tb/tb_sccb_slave_model.sv
// Directed bench for sccb_slave_model: a bit-banged SCCB master on a wired-AND SIOD line.
`timescale 1ns/1ps
module tb_sccb_slave_model;

  localparam int unsigned HP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sioc;
  logic        m_sda;
  logic        siod_bus;
  logic        siod_out, siod_oe, wr_valid, rd_valid, busy, id_err;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned wr_cnt = 0;
  int unsigned rd_cnt = 0;
  int unsigned oe_cnt = 0;

  always #5 clk = ~clk;

  assign siod_bus = m_sda & (siod_oe ? siod_out : 1'b1);

  sccb_slave_model #(
    .DEV_ADDR    (8'h78),
    .ADDR_BITS   (6),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sioc     (sioc),
    .i_siod_in  (siod_bus),
    .o_siod_out (siod_out),
    .o_siod_oe  (siod_oe),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_rd_valid (rd_valid),
    .o_busy     (busy),
    .o_id_err   (id_err)
  );

  always @(negedge clk) begin
    if (wr_valid) wr_cnt++;
    if (rd_valid) rd_cnt++;
    if (siod_oe)  oe_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(HP);
    sioc  = 1'b1; tick(HP);
    m_sda = 1'b0; tick(HP);
    sioc  = 1'b0; tick(HP);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(HP);
    sioc  = 1'b1; tick(HP);
    m_sda = 1'b1; tick(HP);
  endtask

  task automatic send_bits(input logic [7:0] b, input int unsigned n);
    logic [7:0] s;
    s = b;
    for (int unsigned i = 0; i < n; i++) begin
      m_sda = s[7];
      s = {s[6:0], 1'b0};
      tick(HP);
      sioc = 1'b1; tick(HP);
      sioc = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda = 1'b1; tick(HP);
    sioc  = 1'b1; tick(HP);
    ack   = siod_bus;
    sioc  = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; tick(HP);
      sioc  = 1'b1; tick(HP);
      d     = {d[6:0], siod_bus};
      sioc  = 1'b0;
    end
    m_sda = nack; tick(HP);
    sioc  = 1'b1; tick(HP);
    sioc  = 1'b0;
  endtask

  task automatic write_at(input logic [15:0] a, input logic [7:0] d, output logic [3:0] acks);
    bus_start();
    send_byte(8'h78, acks[3]);
    send_byte(a[15:8], acks[2]);
    send_byte(a[7:0], acks[1]);
    send_byte(d, acks[0]);
    bus_stop();
  endtask

  task automatic read_at(input logic [15:0] a, input logic rep, output logic [7:0] d,
                         output logic [3:0] acks);
    bus_start();
    send_byte(8'h78, acks[3]);
    send_byte(a[15:8], acks[2]);
    send_byte(a[7:0], acks[1]);
    if (!rep) bus_stop();
    bus_start();
    send_byte(8'h79, acks[0]);
    read_byte(1'b1, d);
    tick(HP / 2);
    bus_stop();
  endtask

  initial begin
    logic [3:0]  acks;
    logic [7:0]  d;
    logic        a;
    int unsigned w0, r0, o0;

    rst = 1'b1; sioc = 1'b1; m_sda = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(2);
    chk("rst_flags", {siod_out, siod_oe, wr_valid, rd_valid, busy, id_err}, 6'b100000);
    chk("rst_wr_addr", wr_addr, 16'h0000);
    chk("rst_wr_data", wr_data, 8'h00);

    // 3-phase write of 0x42 to 0x3008
    w0 = wr_cnt;
    bus_start();
    chk("t1_busy", busy, 1'b1);
    send_byte(8'h78, acks[3]);
    send_byte(8'h30, acks[2]);
    send_byte(8'h08, acks[1]);
    send_byte(8'h42, acks[0]);
    bus_stop();
    chk("t1_acks", acks, 4'b0000);
    chk("t1_wr_pulses", wr_cnt - w0, 1);
    chk("t1_wr_addr", wr_addr, 16'h3008);
    chk("t1_wr_data", wr_data, 8'h42);
    chk("t1_busy_after_stop", busy, 1'b0);

    // 2-phase write then read back
    w0 = wr_cnt; r0 = rd_cnt;
    bus_start();
    send_byte(8'h78, acks[3]);
    send_byte(8'h30, acks[2]);
    send_byte(8'h08, acks[1]);
    bus_stop();
    bus_start();
    send_byte(8'h79, acks[0]);
    read_byte(1'b1, d);
    tick(HP / 2);
    chk("t2_released_before_stop", siod_oe, 1'b0);
    bus_stop();
    chk("t2_acks", acks, 4'b0000);
    chk("t2_data", d, 8'h42);
    chk("t2_rd_pulses", rd_cnt - r0, 1);
    chk("t2_no_write", wr_cnt - w0, 0);

    // address 0x0048 aliases onto register 8
    read_at(16'h0048, 1'b1, d, acks);
    chk("t2b_alias_acks", acks, 4'b0000);
    chk("t2b_alias_data", d, 8'h42);

    // wrong ID: never driven, flagged, nothing written
    w0 = wr_cnt; o0 = oe_cnt;
    bus_start();
    send_byte(8'h60, a);
    chk("t3_id_nack", a, 1'b1);
    send_byte(8'h11, a);
    chk("t3_byte_nack", a, 1'b1);
    bus_stop();
    chk("t3_oe_never", oe_cnt - o0, 0);
    chk("t3_no_write", wr_cnt - w0, 0);
    chk("t3_id_err", id_err, 1'b1);
    w0 = wr_cnt;
    write_at(16'h0010, 8'h5A, acks);
    chk("t3_next_acks", acks, 4'b0000);
    chk("t3_next_pulses", wr_cnt - w0, 1);
    chk("t3_next_addr", wr_addr, 16'h0010);
    chk("t3_next_data", wr_data, 8'h5A);
    chk("t3_id_err_sticky", id_err, 1'b1);

    // STOP after 4 bits of the low address byte
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h78, acks[3]);
    send_byte(8'h30, acks[2]);
    send_bits(8'h08, 4);
    bus_stop();
    chk("t4_acks", acks[3:2], 2'b00);
    chk("t4_busy", busy, 1'b0);
    chk("t4_no_write", wr_cnt - w0, 0);
    read_at(16'h3008, 1'b0, d, acks);
    chk("t4_mem_kept", d, 8'h42);

    // repeated start reads, no intervening STOP
    w0 = wr_cnt;
    read_at(16'h0005, 1'b1, d, acks);
    chk("t5_acks", acks, 4'b0000);
    chk("t5_data_5", d, 8'h00);
    read_at(16'h0010, 1'b1, d, acks);
    chk("t5_data_10", d, 8'h5A);
    chk("t5_no_write", wr_cnt - w0, 0);

    // reset while the responder drives read data
    bus_start();
    send_byte(8'h78, acks[3]);
    send_byte(8'h30, acks[2]);
    send_byte(8'h08, acks[1]);
    bus_start();
    send_byte(8'h79, acks[0]);
    tick(6);
    chk("t6_pre_oe", {siod_oe, siod_out}, 2'b10);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_flags", {siod_out, siod_oe, wr_valid, rd_valid, busy, id_err}, 6'b100000);
    chk("t6_rst_wr_addr", wr_addr, 16'h0000);
    chk("t6_rst_wr_data", wr_data, 8'h00);
    sioc = 1'b1; m_sda = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(4);
    read_at(16'h3008, 1'b0, d, acks);
    chk("t6_acks_after", acks, 4'b0000);
    chk("t6_mem_cleared", d, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
